main: RTL and testbench

- Top-level AES-256 encryption block.
- An external host loads a 256-bit key as 16 sequential 16-bit words, each marked by a rising edge on a write strobe.
- When the 16th word lands, the block encrypts the 128-bit plaintext input once, using an iterative AES-256 core, and presents the ciphertext with a valid flag.

---
 rtl/aes_pkg.sv | 113 +++++++++++
 rtl/aes256_core.sv | 81 ++++++++
 rtl/main.sv | 83 ++++++++
 tb/tb_main.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-256 building blocks shared by the core and the top level.
// Holds the S-box, Rcon, GF(2^8) helpers and the per-round byte transforms.
// All functions are purely combinational and operate on FIPS-197 big-endian blocks.
package aes_pkg;

  localparam int NR    = 14;
  localparam int KEY_W = 256;
  localparam int BLK_W = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } core_st_e;

  // Forward S-box packed MSB-first: entry x lives at bits [{~x,3'b0} +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  // Rcon[i] for i = 1..7, which is all AES-256 needs.
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte n sits at [127-8n -: 8]; state is column-major, so row r of
  // column c is byte r+4c and rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ gmul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gmul3(a3),
            gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

endpackage

// File: rtl/aes256_core.sv
// Iterative AES-256 encryptor: one round per clk, round keys expanded on the fly.
// Ports: clk/rst, start pulse with key/pt; ct holds the state, done pulses for one
// cycle when ct is final, busy covers the computation through the done cycle.
module aes256_core
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] pt,
  output logic [BLK_W-1:0] ct,
  output logic             done,
  output logic             busy
);

  core_st_e         st_q, st_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0] kwin_q, kwin_d;   // sliding window of 8 expanded key words
  logic [3:0]       rnd_q, rnd_d;
  logic             done_q, done_d;

  // Produce the next four expanded words from the 8-word window. Round r
  // (odd) creates words starting at an index divisible by 8, which takes
  // RotWord+Rcon; even rounds land on index mod 8 == 4, SubWord only.
  function automatic logic [127:0] key_step(input logic [255:0] w, input logic [3:0] rnd);
    logic [31:0] t, n0, n1, n2, n3;
    if (rnd[0]) t = sub_word({w[23:0], w[31:24]}) ^ {rcon(rnd[3:1] + 3'd1), 24'h0};
    else        t = sub_word(w[31:0]);
    n0 = w[255:224] ^ t;
    n1 = w[223:192] ^ n0;
    n2 = w[191:160] ^ n1;
    n3 = w[159:128] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      kwin_q  <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      kwin_q  <= kwin_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    kwin_d  = kwin_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    if (start) begin
      // A start always wins, including mid-computation: restart from round 0.
      state_d = pt ^ key[255:128];
      kwin_d  = key;
      rnd_d   = 4'd1;
      st_d    = ST_RUN;
    end else if (st_q == ST_RUN) begin
      // Round r uses the upper-half-shifted window's low 128 bits.
      state_d = aes_round(state_q, kwin_q[127:0], rnd_q == 4'(NR));
      kwin_d  = {kwin_q[127:0], key_step(kwin_q, rnd_q)};
      rnd_d   = rnd_q + 4'd1;
      if (rnd_q == 4'(NR)) begin
        st_d   = ST_IDLE;
        done_d = 1'b1;
      end
    end
  end

  assign ct   = state_q;
  assign done = done_q;
  assign busy = (st_q == ST_RUN) || done_q;

endmodule

// File: rtl/main.sv
// AES-256 top: strobe-clocked key capture, toggle synchronizer into clk, output registers.
// Ports: key_w_clk/in load 16x16-bit key words; plaintext sampled at start;
// ciphertext/ct_valid held until next start or reset; busy during the rounds.
module main
  import aes_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_w_clk,
  input  logic [WORD_W-1:0] in,
  input  logic [BLK_W-1:0]  plaintext,
  output logic [BLK_W-1:0]  ciphertext,
  output logic              ct_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(KEY_WORDS);

  logic [KEY_W-1:0] key_sr_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             load_tgl_q;
  logic [2:0]       sync_q;      // [0],[1] synchronizer, [2] edge register
  logic             start;
  logic [BLK_W-1:0] ct_q, core_ct;
  logic             ct_valid_q, core_done, core_busy;

  // Strobe domain: strobes can be narrower/faster than clk, so they act as a clock.
  always_ff @(posedge key_w_clk or posedge rst) begin
    if (rst) begin
      key_sr_q   <= '0;
      word_cnt_q <= '0;
      load_tgl_q <= 1'b0;
    end else begin
      key_sr_q <= {key_sr_q[KEY_W-WORD_W-1:0], in};
      if (word_cnt_q == CNT_W'(KEY_WORDS - 1)) begin
        word_cnt_q <= '0;
        load_tgl_q <= ~load_tgl_q;
      end else begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], load_tgl_q};
  end

  // Any toggle change marks a completed key; key_sr is stable until the next
  // strobe, which is not allowed while busy, so it is read without resync.
  assign start = sync_q[2] ^ sync_q[1];

  aes256_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key_sr_q),
    .pt    (plaintext),
    .ct    (core_ct),
    .done  (core_done),
    .busy  (core_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
    end else if (start) begin
      ct_valid_q <= 1'b0;
    end else if (core_done) begin
      ct_q       <= core_ct;
      ct_valid_q <= 1'b1;
    end
  end

  assign ciphertext = ct_q;
  assign ct_valid   = ct_valid_q;
  assign busy       = core_busy;

endmodule

// File: tb/tb_main.sv
`timescale 1ns/1ps
module tb_main;

  localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO  = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_w_clk = 1'b0;
  logic [15:0]  key_in = '0;
  logic [127:0] plaintext = '0;
  logic [127:0] ciphertext;
  logic         ct_valid;
  logic         busy;

  main #(.WORD_W(16), .KEY_WORDS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_w_clk  (key_w_clk),
    .in         (key_in),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .ct_valid   (ct_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic vld_prev = 1'b0;
  logic [127:0] sb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every rising ct_valid consumes one expected ciphertext.
  always @(negedge clk) begin
    if (ct_valid && !vld_prev) begin
      rise_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_valid", 128'(ct_valid), 128'(0));
      else chk("ct", ciphertext, sb.pop_front());
    end
    if (!ct_valid && vld_prev) fall_cyc = cyc;
    vld_prev = ct_valid;
  end

  task automatic send_words(input logic [255:0] k, input int first, input int n,
                            input int lo, input int hi);
    for (int i = first; i < first + n; i++) begin
      key_in = k[255-16*i -: 16];
      #(lo);
      key_w_clk = 1'b1;
      strobe_cyc = cyc;
      #(hi);
      key_w_clk = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  task automatic wait_busy(input string tag);
    int k = 0;
    while (!busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!busy) chk({tag, "_busy_timeout"}, 128'(busy), 128'(1));
  endtask

  initial begin
    int viol;
    repeat (3) @(negedge clk);
    chk("rst_ct", ciphertext, 128'(0));
    chk("rst_valid", 128'(ct_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;

    // FIPS-197 vector with ordinary strobes.
    @(negedge clk);
    plaintext = PT_FIPS;
    sb.push_back(CT_FIPS);
    send_words(KEY_FIPS, 0, 16, 7, 3);
    wait_done("fips");
    chk("fips_latency_le18", 128'((rise_cyc - strobe_cyc) <= 18), 128'(1));
    @(negedge clk);
    chk("fips_valid", 128'(ct_valid), 128'(1));
    chk("fips_busy_low", 128'(busy), 128'(0));
    repeat (20) @(negedge clk);
    chk("fips_hold", ciphertext, CT_FIPS);

    // Reload with all-zero key and plaintext.
    plaintext = '0;
    sb.push_back(CT_ZERO);
    send_words(256'(0), 0, 16, 7, 3);
    wait_done("zero");
    chk("reload_gap", 128'(rise_cyc - fall_cyc), 128'(15));

    // Same FIPS key with 1 ns strobes every 5 ns.
    @(negedge clk);
    plaintext = PT_FIPS;
    sb.push_back(CT_FIPS);
    send_words(KEY_FIPS, 0, 16, 4, 1);
    wait_done("fast");

    // Reset five clocks into a computation.
    @(negedge clk);
    send_words(256'(0), 0, 16, 7, 3);
    wait_busy("rstmid");
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ct", ciphertext, 128'(0));
    chk("rstmid_valid", 128'(ct_valid), 128'(0));
    chk("rstmid_busy", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Partial load, long idle, then the remaining words.
    @(negedge clk);
    send_words(KEY_FIPS, 0, 8, 7, 3);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (ct_valid || busy) viol++;
    end
    chk("partial_idle", 128'(viol), 128'(0));
    sb.push_back(CT_FIPS);
    send_words(KEY_FIPS, 8, 8, 7, 3);
    wait_done("partial");

    // Plaintext changed on cycle 3 of the computation must not matter.
    @(negedge clk);
    plaintext = PT_FIPS;
    sb.push_back(CT_FIPS);
    send_words(KEY_FIPS, 0, 16, 7, 3);
    wait_busy("ptchg");
    repeat (3) @(posedge clk);
    #1 plaintext = ~PT_FIPS;
    wait_done("ptchg");
    plaintext = PT_FIPS;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
